// File: rtl/tabellone_punteggi.sv
// Purpose : per-game round tallies, saturating cross-game totals and end-of-game pulse,
//           sampled every cycle downstream of the game FSMD.
// Latency : one cycle; every output is a register updated by inputs sampled on the previous edge.
// Backpressure: none; inputs are sampled unconditionally every cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   inizia              start-of-game flag (same signal the FSMD sees)
//   manche[1:0]         round result: 00 none, 01 P1, 10 P2, 11 tie
//   partita[1:0]        game result:  00 running, 01 P1, 10 P2, 11 draw
//   vinte1/vinte2/pareggi       per-game round counters (CNT_W)
//   partite1/partite2/partite_pari  cross-game totals (MATCH_W)
//   fine                one-cycle completed-game pulse
//   vincitore[1:0]      last completed game result, held
//   in_gioco            high while a game is tracked
module tabellone_punteggi #(
  parameter int CNT_W   = 8,
  parameter int MATCH_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inizia,
  input  logic [1:0]         manche,
  input  logic [1:0]         partita,
  output logic [CNT_W-1:0]   vinte1,
  output logic [CNT_W-1:0]   vinte2,
  output logic [CNT_W-1:0]   pareggi,
  output logic [MATCH_W-1:0] partite1,
  output logic [MATCH_W-1:0] partite2,
  output logic [MATCH_W-1:0] partite_pari,
  output logic               fine,
  output logic [1:0]         vincitore,
  output logic               in_gioco
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GIOCO = 2'b01,
    FINE  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic clr_rounds;
  logic count_en;
  logic game_done;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [MATCH_W-1:0] inc_match(input logic [MATCH_W-1:0] v);
    return (&v) ? v : v + MATCH_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    // inizia always (re)starts a game, whatever the current state; the FSMD
    // spends that cycle configuring, so its round/game results are ignored.
    clr_rounds = inizia;
    count_en   = (state == GIOCO) && !inizia;
    game_done  = count_en && (partita != 2'b00);
    case (state)
      IDLE: begin
        if (inizia) state_nxt = GIOCO;
      end
      GIOCO: begin
        if (inizia)         state_nxt = GIOCO;
        else if (game_done) state_nxt = FINE;
      end
      FINE: begin
        state_nxt = inizia ? GIOCO : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vinte1       <= '0;
      vinte2       <= '0;
      pareggi      <= '0;
      partite1     <= '0;
      partite2     <= '0;
      partite_pari <= '0;
      fine         <= 1'b0;
      vincitore    <= 2'b00;
      in_gioco     <= 1'b0;
    end else begin
      in_gioco <= (state_nxt == GIOCO);
      fine     <= game_done;

      if (clr_rounds) begin
        vinte1  <= '0;
        vinte2  <= '0;
        pareggi <= '0;
      end else if (count_en) begin
        // The round carried alongside the final game result still counts.
        case (manche)
          2'b01:   vinte1  <= inc_cnt(vinte1);
          2'b10:   vinte2  <= inc_cnt(vinte2);
          2'b11:   pareggi <= inc_cnt(pareggi);
          default: ;
        endcase
      end

      if (game_done) begin
        vincitore <= partita;
        case (partita)
          2'b01:   partite1     <= inc_match(partite1);
          2'b10:   partite2     <= inc_match(partite2);
          2'b11:   partite_pari <= inc_match(partite_pari);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tabellone_punteggi.sv
module tb_tabellone_punteggi;

  logic       clk;
  logic       rst_n;
  logic       inizia;
  logic [1:0] manche;
  logic [1:0] partita;

  logic [7:0] vinte1, vinte2, pareggi;
  logic [3:0] partite1, partite2, partite_pari;
  logic       fine, in_gioco;
  logic [1:0] vincitore;

  logic [1:0] vinte1_s, vinte2_s, pareggi_s;
  logic [1:0] partite1_s, partite2_s, partite_pari_s;
  logic       fine_s, in_gioco_s;
  logic [1:0] vincitore_s;

  tabellone_punteggi dut (
    .clk(clk), .rst_n(rst_n), .inizia(inizia), .manche(manche), .partita(partita),
    .vinte1(vinte1), .vinte2(vinte2), .pareggi(pareggi),
    .partite1(partite1), .partite2(partite2), .partite_pari(partite_pari),
    .fine(fine), .vincitore(vincitore), .in_gioco(in_gioco)
  );

  tabellone_punteggi #(.CNT_W(2), .MATCH_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .inizia(inizia), .manche(manche), .partita(partita),
    .vinte1(vinte1_s), .vinte2(vinte2_s), .pareggi(pareggi_s),
    .partite1(partite1_s), .partite2(partite2_s), .partite_pari(partite_pari_s),
    .fine(fine_s), .vincitore(vincitore_s), .in_gioco(in_gioco_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         sat;
    logic [7:0] v1, v2, pr, t1, t2, tp;
    logic       f;
    logic [1:0] w;
    logic       g;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   vec_id   = 0;
  bit   sat_mode = 1'b0;
  logic probe    = 1'b0;

  task automatic cmp(input int id, input string nm, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL vec%0d %s got=%0h exp=%0h", id, nm, got, want);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge (or on probe for the
  // asynchronous-reset check) and matched against the oldest expectation.
  always @(negedge clk or posedge probe) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp(e.id, "vinte1",       e.sat ? 8'(vinte1_s)       : vinte1,             e.v1);
      cmp(e.id, "vinte2",       e.sat ? 8'(vinte2_s)       : vinte2,             e.v2);
      cmp(e.id, "pareggi",      e.sat ? 8'(pareggi_s)      : pareggi,            e.pr);
      cmp(e.id, "partite1",     e.sat ? 8'(partite1_s)     : 8'(partite1),       e.t1);
      cmp(e.id, "partite2",     e.sat ? 8'(partite2_s)     : 8'(partite2),       e.t2);
      cmp(e.id, "partite_pari", e.sat ? 8'(partite_pari_s) : 8'(partite_pari),   e.tp);
      cmp(e.id, "fine",         e.sat ? 8'(fine_s)         : 8'(fine),           8'(e.f));
      cmp(e.id, "vincitore",    e.sat ? 8'(vincitore_s)    : 8'(vincitore),      8'(e.w));
      cmp(e.id, "in_gioco",     e.sat ? 8'(in_gioco_s)     : 8'(in_gioco),       8'(e.g));
    end
  end

  task automatic push(input logic [7:0] v1, v2, pr, t1, t2, tp,
                      input logic f, input logic [1:0] w, input logic g);
    exp_t x;
    x.id = vec_id; x.sat = sat_mode;
    x.v1 = v1; x.v2 = v2; x.pr = pr; x.t1 = t1; x.t2 = t2; x.tp = tp;
    x.f = f; x.w = w; x.g = g;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Drive one cycle of inputs (called at posedge+1) and queue the expected
  // outputs after the next rising edge.
  task automatic step(input logic ini, input logic [1:0] m, input logic [1:0] p,
                      input logic [7:0] v1, v2, pr, t1, t2, tp,
                      input logic f, input logic [1:0] w, input logic g);
    inizia = ini; manche = m; partita = p;
    @(posedge clk);
    #1;
    push(v1, v2, pr, t1, t2, tp, f, w, g);
  endtask

  initial begin
    rst_n = 1'b0; inizia = 1'b0; manche = 2'b00; partita = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle filtering: results ignored without inizia.
    //    ini  man    par    v1 v2 pr t1 t2 tp f  w      g
    step(0, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(0, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    step(0, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Player 1 game win: manche in the inizia cycle is ignored.
    step(1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b10, 2'b00, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b11, 2'b00, 1, 1, 1, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b01, 2, 1, 1, 1, 0, 0, 1, 2'b01, 0);
    step(0, 2'b00, 2'b00, 2, 1, 1, 1, 0, 0, 0, 2'b01, 0);
    step(0, 2'b01, 2'b10, 2, 1, 1, 1, 0, 0, 0, 2'b01, 0);

    // Restart mid-game: inizia with partita=10 restarts, no count, no pulse.
    step(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b01, 1);
    step(0, 2'b10, 2'b00, 0, 1, 0, 1, 0, 0, 0, 2'b01, 1);
    step(0, 2'b10, 2'b00, 0, 2, 0, 1, 0, 0, 0, 2'b01, 1);
    step(1, 2'b10, 2'b10, 0, 0, 0, 1, 0, 0, 0, 2'b01, 1);
    step(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b01, 1);

    // Back-to-back: draw, inizia in the FINE cycle, then player 2 wins.
    step(0, 2'b11, 2'b11, 0, 0, 1, 1, 0, 1, 1, 2'b11, 0);
    step(1, 2'b01, 2'b00, 0, 0, 0, 1, 0, 1, 0, 2'b11, 1);
    step(0, 2'b10, 2'b00, 0, 1, 0, 1, 0, 1, 0, 2'b11, 1);
    step(0, 2'b10, 2'b10, 0, 2, 0, 1, 1, 1, 1, 2'b10, 0);
    step(0, 2'b00, 2'b00, 0, 2, 0, 1, 1, 1, 0, 2'b10, 0);

    // Asynchronous reset between edges: outputs clear with no rising edge.
    @(negedge clk);
    #1 rst_n = 1'b0;
    push(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturation on the narrow instance (CNT_W=2, MATCH_W=2).
    sat_mode = 1'b1;
    step(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b00, 2, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b00, 3, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b00, 3, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    step(0, 2'b01, 2'b01, 3, 0, 0, 1, 0, 0, 1, 2'b01, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b01, 1);
    step(0, 2'b01, 2'b01, 1, 0, 0, 2, 0, 0, 1, 2'b01, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 2, 0, 0, 0, 2'b01, 1);
    step(0, 2'b01, 2'b01, 1, 0, 0, 3, 0, 0, 1, 2'b01, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 3, 0, 0, 0, 2'b01, 1);
    step(0, 2'b01, 2'b01, 1, 0, 0, 3, 0, 0, 1, 2'b01, 0);
    step(0, 2'b00, 2'b00, 1, 0, 0, 3, 0, 0, 0, 2'b01, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tabellone_punteggi.md
# tabellone_punteggi

Scoreboard stage placed directly downstream of the game FSMD: it samples the per-round result `manche` and the game result `partita` every clock, and keeps the running tallies of the current game. It also keeps saturating totals of games won per player and draws across games, and emits a one-cycle end-of-game pulse with the latched winner. It forms the observable output of the game datapath for display and verification.

## Interface
- `CNT_W`, default 8: width of the per-game round counters.
- `MATCH_W`, default 4: width of the cross-game totals.

Ports:
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `inizia`  in  1  start-of-game flag, the same signal driven into the FSMD.
- `manche`  in  2  round result from the FSMD:
  - 00: no valid round
  - 01: player 1 wins the round
  - 10: player 2 wins the round
  - 11: round is a tie
- `partita`  in  2  game result from the FSMD:
  - 00: game in progress
  - 01: player 1 wins the game
  - 10: player 2 wins the game
  - 11: game is a draw
- `vinte1`  out  CNT_W  rounds won by player 1 in the current game.
- `vinte2`  out  CNT_W  rounds won by player 2 in the current game.
- `pareggi`  out  CNT_W  tied rounds in the current game.
- `partite1`  out  MATCH_W  games won by player 1, total.
- `partite2`  out  MATCH_W  games won by player 2, total.
- `partite_pari`  out  MATCH_W  drawn games, total.
- `fine`  out  1  one-cycle pulse marking a completed game.
- `vincitore`  out  2  result of the last completed game, in `partita` encoding; held until the next completed game.
- `in_gioco`  out  1  high while a game is being tracked (state GIOCO).

## Operation
- **State machine**, 2-bit state with three states:
  - IDLE: reset state; `manche` and `partita` are ignored.
  - GIOCO: a game is being tracked.
  - FINE: one cycle after a game completes.
- **Transitions:**
  - IDLE -> GIOCO on `inizia`=1.
  - GIOCO -> GIOCO on `inizia`=1. This is a restart: the round counters clear, the abandoned game is not counted, and `partita` is ignored in that cycle.
  - GIOCO -> FINE on `inizia`=0 with `partita`!=00.
  - GIOCO -> GIOCO otherwise.
  - FINE -> GIOCO if `inizia`=1, else FINE -> IDLE.
- **Entering GIOCO from any state:** `vinte1`, `vinte2` and `pareggi` clear to 0. `manche` is ignored in the `inizia` cycle, because the FSMD uses that cycle to configure the game.
- **In GIOCO with `inizia`=0:**
  - `manche` 01/10/11 increments `vinte1`/`vinte2`/`pareggi` respectively.
  - 00 counts nothing.
  - The round carried in the same cycle as `partita`!=00 is counted.
- **On a game completing (GIOCO, `inizia`=0, `partita`!=00):**
  - `vincitore` <= `partita`.
  - `partite1`, `partite2` or `partite_pari` increments according to the result.
  - `fine` <= 1 for exactly one cycle.
- **Saturation:** all counters saturate at their all-ones value and never wrap.
- **Hold behaviour:** round counters hold their values in FINE and IDLE until the next `inizia`. Totals clear only on reset.

## Timing
- **Registered outputs:** every output is a register. The effect of inputs sampled at rising edge N is visible after edge N.
- **End-of-game latency:**
  - `fine` is high for the single cycle following the sampling edge.
  - `in_gioco` drops in that same cycle.
  - `vincitore` and the totals are updated in that same cycle.
- **Reset:**
  - Applies asynchronously; released synchronously to `clk` by the surrounding system.
  - All counters, `vincitore`=00, `fine`=0, `in_gioco`=0, state IDLE.
- **Reset mid-game:** discards all tallies, including the totals.
- **Simultaneous `inizia`=1 and `partita`!=00 in GIOCO:** restart wins; no totals change and `fine` stays 0.
- **`inizia`=1 while in FINE:** handled as a new game; back-to-back games lose no cycles.
- **`partita`!=00 while in IDLE:** ignored; no pulse, no count.

## Test plan
- **Reset state.** Stimulus: reset asserted mid-cycle with no clock edge. Required response: all outputs 0 immediately.
- **Player 1 game win.** Stimulus: `inizia`=1, then `manche` sequence 01, 10, 11, 01 with `partita`=01 on the last round. Required response:
  - `vinte1`=2, `vinte2`=1, `pareggi`=1.
  - `fine` high one cycle; `vincitore`=01; `partite1`=1.
  - `in_gioco`=0 afterwards.
- **Restart mid-game.** Stimulus: `inizia`=1, two rounds of 10, then `inizia`=1 with `partita`=10 in the same cycle. Required response:
  - Round counters back to 0.
  - `partite2`=0, `fine` never high, state GIOCO.
- **Back-to-back games.** Stimulus: game ending in draw (`partita`=11), with `inizia`=1 in the FINE cycle, then a game won by player 2. Required response:
  - `partite_pari`=1, `partite2`=1.
  - Two `fine` pulses, round counters cleared between games.
- **Saturation.** Stimulus: CNT_W=2, MATCH_W=2; play five rounds of 01 and win four games with `partita`=01. Required response: `vinte1` stays at 3 and `partite1` stays at 3; neither wraps.
- **Idle filtering.** Stimulus: from reset with no `inizia`, drive `manche`=01 and `partita`=10 for three cycles. Required response: all counters 0, `fine` 0, `in_gioco` 0.
